// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping datapath.
// Run-control state encoding and BCD digit limits.
package stopwatch_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] DIG_MAX_10 = 4'd9;
    localparam logic [BCD_W-1:0] DIG_MAX_6  = 4'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_e;
endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit, 0..MAX, wrapping with a combinational carry-out.
// Chained by carry to form a single-cycle ripple counter.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = DIG_MAX_10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [0:BCD_W-1] digit,
    output logic             carry
);
    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;
    logic             at_max;

    assign at_max = (digit_q == MAX);
    assign carry  = inc & at_max;
    assign digit  = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = at_max ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end
endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timekeeping: clock prescaler, run/pause FSM and a
// six-digit BCD MM:SS.cc counter with sticky wrap flag.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_stop,
    input  logic             clear,
    output logic [0:BCD_W-1] cs_ones,
    output logic [0:BCD_W-1] cs_tens,
    output logic [0:BCD_W-1] s_ones,
    output logic [0:BCD_W-1] s_tens,
    output logic [0:BCD_W-1] m_ones,
    output logic [0:BCD_W-1] m_tens,
    output logic             running,
    output logic             overflow
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    sw_state_e   state_q;
    logic [PW-1:0] presc_q;
    logic        running_q;
    logic        overflow_q;
    logic        tick;
    logic [6:0]  inc;
    logic [5:0]  carry;

    // A pulse edge freezes the prescaler, so pause never eats a tick.
    assign tick = (state_q == RUNNING) & ~start_stop & ~clear
                & (presc_q == PRE_MAX);

    assign inc[0]   = tick;
    assign inc[6:1] = carry;
    assign running  = running_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (start_stop) begin
            unique case (state_q)
                IDLE: begin
                    state_q   <= RUNNING;
                    presc_q   <= '0;
                    running_q <= 1'b1;
                end
                RUNNING: begin
                    state_q   <= PAUSED;
                    running_q <= 1'b0;
                end
                PAUSED: begin
                    state_q   <= RUNNING;
                    running_q <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end else if (state_q == RUNNING) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (carry[5]) begin
                overflow_q <= 1'b1;
            end
        end
    end

    bcd_digit_counter #(.MAX(DIG_MAX_10)) u_cs_ones (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(inc[0]),
        .digit(cs_ones), .carry(carry[0])
    );
    bcd_digit_counter #(.MAX(DIG_MAX_10)) u_cs_tens (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(inc[1]),
        .digit(cs_tens), .carry(carry[1])
    );
    bcd_digit_counter #(.MAX(DIG_MAX_10)) u_s_ones (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(inc[2]),
        .digit(s_ones), .carry(carry[2])
    );
    bcd_digit_counter #(.MAX(DIG_MAX_6)) u_s_tens (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(inc[3]),
        .digit(s_tens), .carry(carry[3])
    );
    bcd_digit_counter #(.MAX(DIG_MAX_10)) u_m_ones (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(inc[4]),
        .digit(m_ones), .carry(carry[4])
    );
    bcd_digit_counter #(.MAX(DIG_MAX_6)) u_m_tens (
        .clk(clk), .rst_n(rst_n), .clr(clear), .inc(inc[5]),
        .digit(m_tens), .carry(carry[5])
    );
endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: DIV=10 and DIV=1 instances
// compared every cycle against a total-centiseconds model.
module tb_stopwatch_time_counter;
    logic clk = 1'b0;
    logic rst_n;
    logic ss_a, clr_a, ss_b, clr_b;
    logic [0:3] a_c1, a_c10, a_s1, a_s10, a_m1, a_m10;
    logic [0:3] b_c1, b_c10, b_s1, b_s10, b_m1, b_m10;
    logic a_run, a_ovf, b_run, b_ovf;
    logic [23:0] a_dig, b_dig;

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 running, 2 paused; mt = total ticks
    int mt[2], mp[2], mst[2], mov[2];
    int dv[2] = '{10, 1};

    always #5 clk = ~clk;

    stopwatch_time_counter #(.CLK_HZ(10), .TICK_HZ(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start_stop(ss_a), .clear(clr_a),
        .cs_ones(a_c1), .cs_tens(a_c10), .s_ones(a_s1),
        .s_tens(a_s10), .m_ones(a_m1), .m_tens(a_m10),
        .running(a_run), .overflow(a_ovf)
    );

    stopwatch_time_counter #(.CLK_HZ(1), .TICK_HZ(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start_stop(ss_b), .clear(clr_b),
        .cs_ones(b_c1), .cs_tens(b_c10), .s_ones(b_s1),
        .s_tens(b_s10), .m_ones(b_m1), .m_tens(b_m10),
        .running(b_run), .overflow(b_ovf)
    );

    assign a_dig = {a_m10, a_m1, a_s10, a_s1, a_c10, a_c1};
    assign b_dig = {b_m10, b_m1, b_s10, b_s1, b_c10, b_c1};

    typedef struct {
        bit         ss;
        int         idle;
        logic [3:0] cs1;
        logic       run;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(int t);
        int cs, sec, mn;
        cs  = t % 100;
        sec = (t / 100) % 60;
        mn  = t / 6000;
        return {4'(mn / 10), 4'(mn % 10), 4'(sec / 10),
                4'(sec % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic logic legal(logic [23:0] d);
        return d[23:20] <= 5 && d[19:16] <= 9 && d[15:12] <= 5
            && d[11:8] <= 9 && d[7:4] <= 9 && d[3:0] <= 9;
    endfunction

    always @(negedge clk) begin
        chk("A_range", 32'(legal(a_dig)), 32'd1);
        chk("B_range", 32'(legal(b_dig)), 32'd1);
    end

    task automatic mreset(int i);
        mst[i] = 0; mt[i] = 0; mp[i] = 0; mov[i] = 0;
    endtask

    task automatic mstep(int i, bit ss, bit cl);
        if (cl) begin
            mreset(i);
        end else if (ss) begin
            if (mst[i] == 1) mst[i] = 2;
            else begin
                if (mst[i] == 0) mp[i] = 0;
                mst[i] = 1;
            end
        end else if (mst[i] == 1) begin
            mp[i]++;
            if (mp[i] == dv[i]) begin
                mp[i] = 0;
                mt[i]++;
                if (mt[i] == 360000) begin
                    mt[i] = 0;
                    mov[i] = 1;
                end
            end
        end
    endtask

    task automatic cmp();
        chk("A_state", {6'd0, a_ovf, a_run, a_dig},
            {6'd0, 1'(mov[0]), 1'(mst[0] == 1), to_bcd(mt[0])});
        chk("B_state", {6'd0, b_ovf, b_run, b_dig},
            {6'd0, 1'(mov[1]), 1'(mst[1] == 1), to_bcd(mt[1])});
    endtask

    task automatic step(bit sa, bit ca, bit sb, bit cb, bit ck);
        ss_a = sa; clr_a = ca; ss_b = sb; clr_b = cb;
        @(posedge clk);
        mstep(0, sa, ca);
        mstep(1, sb, cb);
        @(negedge clk);
        ss_a = 0; clr_a = 0; ss_b = 0; clr_b = 0;
        if (ck) cmp();
    endtask

    initial begin
        rst_n = 1'b0;
        ss_a = 0; clr_a = 0; ss_b = 0; clr_b = 0;
        mreset(0);
        mreset(1);
        tbl[0] = '{ss: 1'b1, idle: 0, cs1: 4'd0, run: 1'b1};
        tbl[1] = '{ss: 1'b0, idle: 8, cs1: 4'd0, run: 1'b1};
        tbl[2] = '{ss: 1'b0, idle: 0, cs1: 4'd1, run: 1'b1};
        tbl[3] = '{ss: 1'b0, idle: 9, cs1: 4'd2, run: 1'b1};

        repeat (2) @(negedge clk);
        cmp();
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1);

        // first-tick latency on DIV=10
        for (int r = 0; r < 4; r++) begin
            step(tbl[r].ss, 0, 0, 0, 1);
            repeat (tbl[r].idle) step(0, 0, 0, 0, 1);
            chk("tbl_cs_ones", 32'(a_c1), 32'(tbl[r].cs1));
            chk("tbl_running", 32'(a_run), 32'(tbl[r].run));
        end

        // count to 95 with prescaler at 3, pause, resume
        repeat (933) step(0, 0, 0, 0, 1);
        chk("pre_pause", 32'(a_dig[7:0]), 32'h95);
        step(1, 0, 0, 0, 1);
        repeat (50) step(0, 0, 0, 0, 1);
        chk("paused_hold", 32'(a_dig[7:0]), 32'h95);
        chk("paused_run", 32'(a_run), 32'd0);
        step(1, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 1);
        chk("resume_r6", 32'(a_dig[7:0]), 32'h95);
        step(0, 0, 0, 0, 1);
        chk("resume_r7", 32'(a_dig[7:0]), 32'h96);

        // asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_A", {6'd0, a_ovf, a_run, a_dig}, 32'd0);
        mreset(0);
        mreset(1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step(0, 0, 0, 0, 1);
        chk("post_rst_idle", 32'(a_dig), 32'd0);

        // DIV=1: 00:12.34 then clear+start together
        step(0, 0, 1, 0, 1);
        repeat (1234) step(0, 0, 0, 0, 1);
        chk("B_1234", 32'(b_dig), 32'h001234);
        step(0, 0, 1, 1, 1);
        chk("B_clr_win", {6'd0, b_ovf, b_run, b_dig}, 32'd0);

        // one minute, then full wrap
        step(0, 0, 1, 0, 1);
        repeat (6000) step(0, 0, 0, 0, 1);
        chk("B_1min", 32'(b_dig), 32'h010000);
        for (int k = 0; k < 360000 - 6001; k++)
            step(0, 0, 0, 0, (k % 997) == 0);
        cmp();
        chk("B_max", {7'd0, b_ovf, b_dig}, 32'h00595999);
        step(0, 0, 0, 0, 1);
        chk("B_wrap", {7'd0, b_ovf, b_dig}, 32'h01000000);
        step(0, 0, 0, 0, 1);
        chk("B_after", {7'd0, b_ovf, b_dig}, 32'h01000001);
        step(0, 0, 0, 1, 1);

        // random pulses against the model
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0,
                 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
- Upstream timekeeping stage of the stopwatch datapath.
- Divides the system clock down to a centisecond tick and runs a six-digit BCD counter: MM:SS.cc, range 00:00.00 to 59:59.99.
- Start/stop/clear control comes from a small run-control FSM.
- Each 4-bit digit output feeds one BCD-to-seven-segment encoder directly.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (least-significant digit = 1/TICK_HZ s); DIV = CLK_HZ/TICK_HZ, must be >= 1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_stop  in  1  single-cycle pulse, already debounced/synchronised; toggles run/pause
- clear  in  1  single-cycle pulse; zeroes count, returns to IDLE
- cs_ones  out  [0:3]  centiseconds units BCD, bit 0 = MSB
- cs_tens  out  [0:3]  centiseconds tens BCD
- s_ones  out  [0:3]  seconds units BCD
- s_tens  out  [0:3]  seconds tens BCD (0-5)
- m_ones  out  [0:3]  minutes units BCD
- m_tens  out  [0:3]  minutes tens BCD (0-5)
- running  out  1  high while state = RUNNING
- overflow  out  1  sticky; set on wrap past 59:59.99

Behaviour:
- Reset: asynchronous, active-low; clk only; no other reset.
- While rst_n=0: FSM=IDLE, prescaler=0, all digits=0, running=0, overflow=0.
- All outputs are registered.
- FSM states: IDLE, RUNNING, PAUSED.
  - IDLE + start_stop -> RUNNING, prescaler forced to 0.
  - RUNNING + start_stop -> PAUSED; prescaler and digits hold.
  - PAUSED + start_stop -> RUNNING; prescaler resumes from held value, so no partial-tick loss.
  - Any state + clear -> IDLE; digits=0, prescaler=0, overflow=0.
  - clear and start_stop in the same cycle: clear wins, start_stop ignored.
- Prescaler:
  - Counts only in RUNNING, 0..DIV-1.
  - On the edge where prescaler==DIV-1: prescaler->0 and the digit chain increments by one on that same edge.
  - The start_stop edge that enters RUNNING is edge E0. The first increment is visible after edge E0+DIV.
  - DIV=1: the count increments on every RUNNING cycle after E0.
- Digit chain (ripple-carry, single cycle, all digits update on the same edge):
  - cs_ones 0-9, cs_tens 0-9, s_ones 0-9, s_tens 0-5, m_ones 0-9, m_tens 0-5.
  - A digit wraps to 0 and carries when it is at its max and its increment-enable is high.
  - 59:59.99 + 1 -> 00:00.00 on the same edge; overflow set to 1. The count keeps running.
  - overflow stays 1 until clear or reset.
- Digits never hold non-BCD values; unused codes are unreachable.
- running is asserted on edge E0 (RUNNING entry) and deasserted on the pause/clear edge.
- start_stop or clear held longer than one cycle is out of contract. A held start_stop toggles every cycle; no edge detection is done inside this block.

Decomposition:
- Shared package stopwatch_pkg:
  - FSM state encoding (IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2).
  - BCD_W=4.
  - Digit max constants DIG_MAX_10=4'd9, DIG_MAX_6=4'd5.
- Sub-module bcd_digit_counter, instantiated six times and chained by carry:
  - Parameter MAX.
  - Ports: clk, rst_n, clr, inc, digit[0:3], carry.
  - carry = inc & (digit==MAX), combinational.

Test Plan:
- CLK_HZ=10, TICK_HZ=1 (DIV=10):
  - Reset, then start_stop pulse at edge E0 -> running=1 after E0; cs_ones=0 through E0+9; cs_ones=1 after E0+10; cs_ones=2 after E0+20.
  - Run 95 ticks, then pause -> digits frozen at cs_tens=9, cs_ones=5 for 50 cycles; resume -> next increment exactly DIV minus held-prescaler cycles later.
- CLK_HZ=TICK_HZ=1 (DIV=1):
  - Run 6000 ticks -> display 01:00.00 (m_ones=1, all else 0).
  - Run 360000 ticks -> wraps to 00:00.00 with overflow=1 asserted on the wrap edge; continues to 00:00.01 next cycle.
- Mid-count (e.g. 00:12.34 while RUNNING), clear and start_stop in the same cycle -> next edge: IDLE, running=0, all digits 0, overflow 0.
- Assert rst_n=0 asynchronously mid-cycle while RUNNING at nonzero count -> outputs go to 0 immediately without a clock edge. Deassert, clock 20 cycles with no pulses -> count stays 00:00.00.
- Every cycle (bench assertion): each digit within its legal range (s_tens, m_tens <= 5; others <= 9).
